// File: rtl/fast_pow_mod.sv
// fast_pow_mod
//   Sequential square-and-multiply exponentiation engine with one multiply
//   per cycle. It computes a^b truncated to WIDTH bits (mode=0) or
//   a^b mod m (mode=1), and uses a start/done handshake.
//
// Parameters
//   WIDTH      base, modulus and result width in bits
//   EXP_WIDTH  exponent width in bits
//
// Ports
//   clk      in   rising-edge clock
//   reset    in   synchronous, active-high; aborts any operation in flight
//   start    in   request, sampled only while idle
//   mode     in   0 = plain (mod 2^WIDTH), 1 = modular
//   a        in   base
//   b        in   exponent
//   m        in   modulus (ignored in mode 0)
//   busy     out  high while an operation is in progress
//   done     out  result valid; held until the next accepted start
//   error    out  mode 1 with m == 0 (valid with done)
//   result   out  a^b (valid with done)
//   overflow out  only when OVERFLOW_FLAG_EN is defined: in mode 0, some
//                 product that was kept had nonzero upper WIDTH bits
//
// Optional feature macro: OVERFLOW_FLAG_EN
module fast_pow_mod #(
  parameter int WIDTH     = 32,
  parameter int EXP_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 mode,
  input  logic [WIDTH-1:0]     a,
  input  logic [EXP_WIDTH-1:0] b,
  input  logic [WIDTH-1:0]     m,
  output logic                 busy,
  output logic                 done,
  output logic                 error,
`ifdef OVERFLOW_FLAG_EN
  output logic [WIDTH-1:0]     result,
  output logic                 overflow
`else
  output logic [WIDTH-1:0]     result
`endif
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CHECK  = 3'd1,
    S_MUL    = 3'd2,
    S_SQR    = 3'd3,
    S_FINISH = 3'd4
  } state_t;

  state_t               state_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 error_q;
  logic [WIDTH-1:0]     result_q;

  // Operand registers. They carry no reset because every accepted start
  // loads them before they are used.
  logic                 mode_q;
  logic [WIDTH-1:0]     m_q;
  logic [WIDTH-1:0]     base_q;
  logic [WIDTH-1:0]     acc_q;
  logic [EXP_WIDTH-1:0] e_q;

  logic [WIDTH-1:0]     op_a;
  logic [2*WIDTH-1:0]   prod;
  logic [WIDTH-1:0]     base_d;
  logic [WIDTH-1:0]     acc_d;
  logic [WIDTH-1:0]     base_ld;
  logic [WIDTH-1:0]     acc_ld;
  logic [EXP_WIDTH-1:0] e_d;

  // Mode 0 keeps the low half of the product. Mode 1 reduces the full
  // product modulo md. A zero modulus yields 0; this path feeds only the
  // error case, whose result is forced to 0 anyway.
  function automatic logic [WIDTH-1:0] reduce(input logic [2*WIDTH-1:0] p,
                                              input logic              md,
                                              input logic [WIDTH-1:0]  mod);
    logic [2*WIDTH-1:0] r;
    if (!md) begin
      r = p;
    end else if (mod == '0) begin
      r = '0;
    end else begin
      r = p % {{WIDTH{1'b0}}, mod};
    end
    return r[WIDTH-1:0];
  endfunction

  // One shared multiplier. MUL uses acc*base and SQR uses base*base.
  always_comb begin
    op_a    = (state_q == S_MUL) ? acc_q : base_q;
    prod    = {{WIDTH{1'b0}}, op_a} * {{WIDTH{1'b0}}, base_q};
    acc_d   = reduce(prod, mode_q, m_q);
    base_d  = acc_d;
    e_d     = e_q >> 1;
    base_ld = reduce({{WIDTH{1'b0}}, a}, mode, m);
    acc_ld  = reduce({{(2*WIDTH-1){1'b0}}, 1'b1}, mode, m);
  end

`ifdef OVERFLOW_FLAG_EN
  logic overflow_q;
  logic prod_hi_nz;

  always_comb begin
    prod_hi_nz = |prod[2*WIDTH-1:WIDTH];
  end

  assign overflow = overflow_q;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
      result_q <= '0;
`ifdef OVERFLOW_FLAG_EN
      overflow_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            mode_q  <= mode;
            m_q     <= m;
            e_q     <= b;
            base_q  <= base_ld;
            acc_q   <= acc_ld;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
`ifdef OVERFLOW_FLAG_EN
            overflow_q <= 1'b0;
`endif
            // A zero modulus has no meaningful result, so skip straight to FINISH.
            if (mode && (m == '0)) begin
              error_q <= 1'b1;
              state_q <= S_FINISH;
            end else begin
              error_q <= 1'b0;
              state_q <= S_CHECK;
            end
          end
        end
        S_CHECK: begin
          if (e_q == '0) begin
            state_q <= S_FINISH;
          end else if (e_q[0]) begin
            state_q <= S_MUL;
          end else begin
            state_q <= S_SQR;
          end
        end
        S_MUL: begin
          acc_q   <= acc_d;
`ifdef OVERFLOW_FLAG_EN
          if (!mode_q && prod_hi_nz) overflow_q <= 1'b1;
`endif
          state_q <= S_SQR;
        end
        S_SQR: begin
          base_q  <= base_d;
          e_q     <= e_d;
`ifdef OVERFLOW_FLAG_EN
          // The last squaring is never used, so it must not set the flag.
          if (!mode_q && prod_hi_nz && (e_d != '0)) overflow_q <= 1'b1;
`endif
          state_q <= S_CHECK;
        end
        S_FINISH: begin
          result_q <= error_q ? '0 : acc_q;
          done_q   <= 1'b1;
          busy_q   <= 1'b0;
          state_q  <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign error  = error_q;
  assign result = result_q;

endmodule

// File: tb/tb_fast_pow_mod.sv
// Testbench for fast_pow_mod (WIDTH = EXP_WIDTH = 32).
// The reference model computes a^b by plain repeated multiplication.
module tb_fast_pow_mod;

  logic        clk;
  logic        reset;
  logic        start;
  logic        mode;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] m;
  logic        busy;
  logic        done;
  logic        error;
  logic [31:0] result;
`ifdef OVERFLOW_FLAG_EN
  logic        overflow;
`endif

  int tests = 0;
  int fails = 0;

  fast_pow_mod #(.WIDTH(32), .EXP_WIDTH(32)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .mode   (mode),
    .a      (a),
    .b      (b),
    .m      (m),
    .busy   (busy),
    .done   (done),
    .error  (error),
`ifdef OVERFLOW_FLAG_EN
    .result (result),
    .overflow (overflow)
`else
    .result (result)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: a^b as b repeated multiplications, truncated to 32 bits or taken mod m.
  function automatic logic [31:0] model(input logic md, input logic [31:0] aa,
                                        input int unsigned bb, input logic [31:0] mm);
    longint unsigned r;
    longint unsigned x;
    if (md) begin
      if (mm == 0) return 32'd0;
      r = 64'(1) % 64'(mm);
      x = 64'(aa) % 64'(mm);
      for (int unsigned i = 0; i < bb; i++) r = (r * x) % 64'(mm);
    end else begin
      r = 1;
      for (int unsigned i = 0; i < bb; i++) r = (r * 64'(aa)) & 64'hFFFF_FFFF;
    end
    return r[31:0];
  endfunction

  function automatic int exp_latency(input logic md, input logic [31:0] bb, input logic [31:0] mm);
    if (md && mm == 0) return 2;
    return 3 + 2 * $clog2(64'(bb) + 1) + $countones(bb);
  endfunction

  // Launch one operation and count edges, starting with the start edge, until done is seen.
  task automatic run_op(input logic md, input logic [31:0] aa, input logic [31:0] bb,
                        input logic [31:0] mm, output logic [31:0] res, output logic err,
                        output int edges, output int bcnt);
    @(negedge clk);
    start = 1'b1; mode = md; a = aa; b = bb; m = mm;
    @(posedge clk);
    edges = 1;
    #1;
    bcnt = busy ? 1 : 0;
    start = 1'b0; mode = $urandom; a = $urandom; b = $urandom; m = $urandom;
    while (!done && edges < 2000) begin
      @(posedge clk);
      edges++;
      #1;
      if (busy) bcnt++;
    end
    res = result;
    err = error;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b1; mode = 1'b1; a = 32'd5; b = 32'd3; m = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    tests++; if (busy !== 1'b0)    begin fails++; $display("FAIL reset_busy: got %0b expected 0", busy); end
    tests++; if (done !== 1'b0)    begin fails++; $display("FAIL reset_done: got %0b expected 0", done); end
    tests++; if (error !== 1'b0)   begin fails++; $display("FAIL reset_error: got %0b expected 0", error); end
    tests++; if (result !== 32'd0) begin fails++; $display("FAIL reset_result: got %0h expected 0", result); end
`ifdef OVERFLOW_FLAG_EN
    tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL reset_overflow: got %0b expected 0", overflow); end
`endif
    @(negedge clk);
    reset = 1'b0; start = 1'b0;
  endtask

  task automatic test_spec_vectors();
    logic [31:0] res; logic err; int ed; int bc;
    run_op(1'b0, 32'd3, 32'd5, 32'd0, res, err, ed, bc);
    tests++; if (res !== 32'd243) begin fails++; $display("FAIL pow3_5_result: got %0d expected 243", res); end
    tests++; if (ed !== 11)       begin fails++; $display("FAIL pow3_5_latency: got %0d expected 11", ed); end
    tests++; if (err !== 1'b0)    begin fails++; $display("FAIL pow3_5_error: got %0b expected 0", err); end
    run_op(1'b0, 32'd7, 32'd0, 32'd0, res, err, ed, bc);
    tests++; if (res !== 32'd1)   begin fails++; $display("FAIL pow7_0_result: got %0d expected 1", res); end
    tests++; if (ed !== 3)        begin fails++; $display("FAIL pow7_0_latency: got %0d expected 3", ed); end
    tests++; if (bc !== 2)        begin fails++; $display("FAIL pow7_0_busy_cycles: got %0d expected 2", bc); end
    run_op(1'b1, 32'd4, 32'd13, 32'd497, res, err, ed, bc);
    tests++; if (res !== 32'd445) begin fails++; $display("FAIL modpow_result: got %0d expected 445", res); end
    tests++; if (ed !== 3 + 2*4 + 3) begin fails++; $display("FAIL modpow_latency: got %0d expected 14", ed); end
    run_op(1'b1, 32'd4, 32'd13, 32'd1, res, err, ed, bc);
    tests++; if (res !== 32'd0)   begin fails++; $display("FAIL mod1_result: got %0d expected 0", res); end
    run_op(1'b1, 32'd9, 32'd3, 32'd0, res, err, ed, bc);
    tests++; if (err !== 1'b1)    begin fails++; $display("FAIL m0_error: got %0b expected 1", err); end
    tests++; if (res !== 32'd0)   begin fails++; $display("FAIL m0_result: got %0d expected 0", res); end
    tests++; if (ed !== 2)        begin fails++; $display("FAIL m0_latency: got %0d expected 2", ed); end
    run_op(1'b0, 32'd0, 32'd6, 32'd0, res, err, ed, bc);
    tests++; if (res !== 32'd0)   begin fails++; $display("FAIL zero_base_result: got %0d expected 0", res); end
    run_op(1'b1, 32'd8, 32'd0, 32'd1, res, err, ed, bc);
    tests++; if (res !== 32'd0)   begin fails++; $display("FAIL b0_m1_result: got %0d expected 0", res); end
  endtask

  task automatic test_random();
    logic [31:0] res; logic err; int ed; int bc;
    logic md; logic [31:0] aa; logic [31:0] bb; logic [31:0] mm;
    logic [31:0] exp_r;
    for (int i = 0; i < 24; i++) begin
      md = $urandom_range(0, 1);
      aa = $urandom;
      bb = $urandom_range(0, 200);
      mm = (i % 3 == 0) ? 32'($urandom_range(0, 20)) : $urandom;
      exp_r = model(md, aa, bb, mm);
      run_op(md, aa, bb, mm, res, err, ed, bc);
      tests++; if (res !== exp_r) begin fails++; $display("FAIL rand%0d_result: got %0h expected %0h (mode %0b a %0h b %0d m %0h)", i, res, exp_r, md, aa, bb, mm); end
      tests++; if (err !== (md && mm == 0)) begin fails++; $display("FAIL rand%0d_error: got %0b expected %0b", i, err, (md && mm == 0)); end
      tests++; if (ed !== exp_latency(md, bb, mm)) begin fails++; $display("FAIL rand%0d_latency: got %0d expected %0d", i, ed, exp_latency(md, bb, mm)); end
    end
  endtask

  task automatic test_start_while_busy();
    int ed;
    @(negedge clk);
    start = 1'b1; mode = 1'b0; a = 32'd3; b = 32'd5; m = 32'd0;
    @(posedge clk); ed = 1;
    @(negedge clk);
    start = 1'b0; a = 32'd2; b = 32'd9;
    // Pulse start twice mid-run with other operands.
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      start = (k == 1 || k == 4); mode = 1'b1; m = 32'd0;
    end
    @(negedge clk);
    start = 1'b0;
    ed = 0;
    while (!done && ed < 100) begin @(posedge clk); ed++; #1; end
    tests++; if (result !== 32'd243) begin fails++; $display("FAIL busy_start_result: got %0d expected 243", result); end
    tests++; if (error !== 1'b0)     begin fails++; $display("FAIL busy_start_error: got %0b expected 0", error); end
  endtask

  task automatic test_back_to_back();
    // Hold start high across a b=0 run: it is ignored in FINISH and accepted in IDLE next cycle.
    @(negedge clk);
    start = 1'b1; mode = 1'b0; a = 32'd7; b = 32'd0; m = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    tests++; if (done !== 1'b1) begin fails++; $display("FAIL b2b_done_after_finish: got %0b expected 1", done); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL b2b_busy_after_finish: got %0b expected 0", busy); end
    @(posedge clk);
    #1;
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL b2b_done_restart: got %0b expected 0", done); end
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL b2b_busy_restart: got %0b expected 1", busy); end
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    tests++; if (done !== 1'b1 || result !== 32'd1) begin fails++; $display("FAIL b2b_second_result: got done %0b result %0d expected done 1 result 1", done, result); end
  endtask

  task automatic test_reset_midrun();
    logic [31:0] res; logic err; int ed; int bc;
    @(negedge clk);
    start = 1'b1; mode = 1'b1; a = 32'd4; b = 32'd13; m = 32'd497;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    tests++; if (busy !== 1'b0 || done !== 1'b0 || error !== 1'b0 || result !== 32'd0)
      begin fails++; $display("FAIL midrun_reset_outputs: got busy %0b done %0b error %0b result %0d expected all 0", busy, done, error, result); end
    @(negedge clk);
    reset = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL midrun_no_done: got %0b expected 0", done); end
    run_op(1'b1, 32'd4, 32'd13, 32'd497, res, err, ed, bc);
    tests++; if (res !== 32'd445) begin fails++; $display("FAIL after_reset_result: got %0d expected 445", res); end
  endtask

`ifdef OVERFLOW_FLAG_EN
  task automatic test_overflow();
    logic [31:0] res; logic err; int ed; int bc;
    run_op(1'b0, 32'd2, 32'd32, 32'd0, res, err, ed, bc);
    tests++; if (res !== 32'd0)    begin fails++; $display("FAIL ovf32_result: got %0h expected 0", res); end
    tests++; if (overflow !== 1'b1) begin fails++; $display("FAIL ovf32_flag: got %0b expected 1", overflow); end
    run_op(1'b0, 32'd2, 32'd31, 32'd0, res, err, ed, bc);
    tests++; if (res !== 32'h8000_0000) begin fails++; $display("FAIL ovf31_result: got %0h expected 80000000", res); end
    tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL ovf31_flag: got %0b expected 0", overflow); end
    run_op(1'b1, 32'hFFFF_FFF0, 32'd50, 32'hFFFF_FFFB, res, err, ed, bc);
    tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL ovf_mode1_flag: got %0b expected 0", overflow); end
  endtask
`endif

  initial begin
    test_reset();
    test_spec_vectors();
    test_random();
    test_start_while_busy();
    test_back_to_back();
    test_reset_midrun();
`ifdef OVERFLOW_FLAG_EN
    test_overflow();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
